// File: rtl/qspi_fifo_pkg.sv
// Shared constants and helpers for the QSPI TX/RX data-path FIFOs.
package qspi_fifo_pkg;

  localparam int TX_DATA_WIDTH = 32;
  localparam int TX_ADDR_WIDTH = 4;
  localparam int RX_DATA_WIDTH = 32;
  localparam int RX_ADDR_WIDTH = 4;

  // The level counter needs one extra bit so that a completely full FIFO (DEPTH) fits.
  function automatic int level_width(input int addr_width);
    return addr_width + 1;
  endfunction

endpackage

// File: rtl/qspi_fifo_ext_if.sv
// Push/pop and status bundle between the front end (master) and the FIFO (slave).
interface qspi_fifo_ext_if
  import qspi_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 4
) ();

  logic                                 flush;
  logic                                 clr_err;
  logic                                 wr_en;
  logic [DATA_WIDTH-1:0]                wr_data;
  logic                                 rd_en;
  logic [DATA_WIDTH-1:0]                rd_data;
  logic                                 full;
  logic                                 empty;
  logic                                 almost_full;
  logic                                 almost_empty;
  logic [level_width(ADDR_WIDTH)-1:0]   level;
  logic                                 overflow;
  logic                                 underflow;

  modport master (
    output flush, clr_err, wr_en, wr_data, rd_en,
    input  rd_data, full, empty, almost_full, almost_empty, level, overflow, underflow
  );

  modport slave (
    input  flush, clr_err, wr_en, wr_data, rd_en,
    output rd_data, full, empty, almost_full, almost_empty, level, overflow, underflow
  );

endinterface

// File: rtl/qspi_fifo_ram.sv
// FIFO storage: one synchronous write port and one asynchronous read port.
module qspi_fifo_ram #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/qspi_fifo_ext.sv
// Parametrised single-clock FIFO with FWFT option, thresholds, occupancy and sticky errors.
module qspi_fifo_ext
  import qspi_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = TX_DATA_WIDTH,
  parameter int ADDR_WIDTH = TX_ADDR_WIDTH,
  parameter int FWFT       = 0,
  parameter int AF_THRESH  = (1 << ADDR_WIDTH) - 1,
  parameter int AE_THRESH  = 1
) (
  input logic            clk,
  input logic            reset,
  qspi_fifo_ext_if.slave bus
);

  localparam int DEPTH   = 1 << ADDR_WIDTH;
  localparam int LEVEL_W = level_width(ADDR_WIDTH);

  logic [ADDR_WIDTH-1:0] wptr, rptr;
  logic [LEVEL_W-1:0]    level_q, next_level;
  logic                  full_q, empty_q, af_q, ae_q;
  logic                  ovf_q, unf_q;
  logic                  push_ok, pop_ok;
  logic [DATA_WIDTH-1:0] ram_rdata;

  assign push_ok = bus.wr_en & ~full_q  & ~bus.flush & ~reset;
  assign pop_ok  = bus.rd_en & ~empty_q & ~bus.flush & ~reset;

  always_comb begin
    next_level = level_q;
    case ({push_ok, pop_ok})
      2'b10:   next_level = level_q + 1'b1;
      2'b01:   next_level = level_q - 1'b1;
      default: next_level = level_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset || bus.flush) begin
      wptr    <= '0;
      rptr    <= '0;
      level_q <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
      af_q    <= 1'b0;
      ae_q    <= 1'b1;
    end else begin
      if (push_ok) wptr <= wptr + 1'b1;
      if (pop_ok)  rptr <= rptr + 1'b1;
      level_q <= next_level;
      full_q  <= (next_level == LEVEL_W'(DEPTH));
      empty_q <= (next_level == '0);
      af_q    <= (next_level >= LEVEL_W'(AF_THRESH));
      ae_q    <= (next_level <= LEVEL_W'(AE_THRESH));
    end
  end

  // Sticky errors survive flush; a new error in the same cycle as clr_err wins.
  always_ff @(posedge clk) begin
    if (reset) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      ovf_q <= (bus.wr_en & full_q  & ~bus.flush) | (ovf_q & ~bus.clr_err);
      unf_q <= (bus.rd_en & empty_q & ~bus.flush) | (unf_q & ~bus.clr_err);
    end
  end

  qspi_fifo_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_ram (
    .clk   (clk),
    .we    (push_ok),
    .waddr (wptr),
    .wdata (bus.wr_data),
    .raddr (rptr),
    .rdata (ram_rdata)
  );

  generate
    if (FWFT != 0) begin : g_fwft
      assign bus.rd_data = empty_q ? '0 : ram_rdata;
    end else begin : g_reg
      logic [DATA_WIDTH-1:0] rd_q;
      always_ff @(posedge clk) begin
        if (reset || bus.flush) rd_q <= '0;
        else if (pop_ok)        rd_q <= ram_rdata;
      end
      assign bus.rd_data = rd_q;
    end
  endgenerate

  assign bus.full         = full_q;
  assign bus.empty        = empty_q;
  assign bus.almost_full  = af_q;
  assign bus.almost_empty = ae_q;
  assign bus.level        = level_q;
  assign bus.overflow     = ovf_q;
  assign bus.underflow    = unf_q;

endmodule
